// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on lo, remainder on hi.
// Truncates toward zero; the remainder carries the dividend's sign.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             fin_r;
  logic             accept_s;
  logic             dz_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;

  // Unsigned magnitude; the most negative value maps onto itself exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // busy stays high one cycle past FINISH, so gating on it keeps that cycle from accepting a request
  assign accept_s = (state_r == IDLE) && start && !busy;
  assign dz_s     = (divisor == {WIDTH{1'b0}});

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  always_comb begin
    rem_sh_s = {rem_r, quo_r[WIDTH-1]};
    ge_s     = (rem_sh_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_next_s = rem_sh_s[WIDTH-1:0] - dvs_r;
    end else begin
      rem_next_s = rem_sh_s[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !dz_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = RUN;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r    <= {CW{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      fin_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      busy     <= (state_r != IDLE);
      fin_r    <= 1'b0;
      done     <= fin_r | (accept_s & dz_s);
      div_zero <= accept_s & dz_s;
      case (state_r)
        IDLE: begin
          if (accept_s && !dz_s) begin
            quo_r    <= mag(dividend);
            dvs_r    <= mag(divisor);
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= CW'(WIDTH);
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[WIDTH-2:0], ge_s};
          cnt_r <= cnt_r - CW'(1);
        end
        FINISH: begin
          lo    <= sign_q_r ? -quo_r : quo_r;
          hi    <= sign_r_r ? -rem_r : rem_r;
          fin_r <= 1'b1;
        end
        default: begin
          fin_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expectations queued at issue, checked on done.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    longint      lat;
    longint      busy_cyc;
    longint      t0;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the reference result; hi/lo are held on divide-by-zero
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint q;
    longint r;
    e.t0 = $time;
    if (b == 32'd0) begin
      e.lo = m_lo; e.hi = m_hi; e.dz = 1'b1; e.lat = 10; e.busy_cyc = 0;
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      q    = sa / sb_v;
      r    = sa % sb_v;
      e.lo = q[31:0]; e.hi = r[31:0]; e.dz = 1'b0; e.lat = 350; e.busy_cyc = 33;
      m_lo = e.lo; m_hi = e.hi;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; leaves start low after the sampling edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; dividend = a; divisor = b;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check_eq("done_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("lo", 64'(lo), 64'(e.lo));
        check_eq("hi", 64'(hi), 64'(e.hi));
        check_eq("div_zero", 64'(div_zero), 64'(e.dz));
        check_eq("latency", 64'($time - e.t0), 64'(e.lat));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(e.busy_cyc));
      end
      busy_cnt = 0;
    end else if (!busy) begin
      busy_cnt = 0;
    end else begin
      busy_cnt++;
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7);             wait_idle();
    issue(32'hFFFF_FF9C, 32'd7);       wait_idle();
    issue(32'd100, 32'hFFFF_FFF9);     wait_idle();
    issue(32'h0000_0451, 32'h20);      wait_idle();
    issue(32'd5, 32'd0);               wait_idle();
    check_eq("dz_busy_low", 64'(busy), 64'd0);
    issue(32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(32'h8000_0000, 32'd2);       wait_idle();
    issue(32'd0, 32'h8000_0000);       wait_idle();
    issue(32'h7FFF_FFFF, 32'h8000_0000); wait_idle();

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : -32'($urandom_range(1, 1000));
      issue(a, b);
      wait_idle();
    end

    // Abort a 100/7 run with reset at its tenth edge
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_dz", 64'(div_zero), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    issue(32'd9, 32'd3);
    wait_idle();

    // start held with changing operands, then re-issue in the done cycle
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    push_exp(32'd100, 32'd7);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      dividend = $urandom; divisor = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    if (!done) check_eq("done_wait", 64'(done), 64'd1);
    issue(32'd9, 32'd4);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
